hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the in-order MIPS core.
- Tracks in-flight register writes in a DEPTH-entry scoreboard covering EX through WB.
- Produces per-operand forwarding selects, load-use stalls, branch squashes and an exception halt.
- Sits beside the decoder: it takes ID-stage operand info and drives PC/IR hold, EX bubble insertion and the operand forwarding muxes.

Parameters:
REG_BITS, 5, register specifier width; register 0 is hardwired zero.
DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); legal range 2..7.
LOAD_LAT, 2, first stage index at which load data is forwardable; legal range 1..DEPTH.
DELAY_SLOT, 0, 1 = the instruction in ID at branch resolve executes (no squash); 0 = squash it.
EXC_W, 8, exception code width.
TRAP_STALL, 8'h80, exception code meaning "stall one cycle, not fatal".

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_BITS  ID source register rs
id_rt  in  REG_BITS  ID source register rt
id_rs_used  in  1  instruction reads rs
id_rt_used  in  1  instruction reads rt
id_rd  in  REG_BITS  ID destination register
id_reg_write  in  1  instruction writes id_rd
id_mem2reg  in  1  instruction is a load
ex_br_enable  in  1  branch taken, resolved in EX this cycle
wb_exception  in  EXC_W  exception code at WB
stall_if  out  1  hold PC and IR this cycle
bubble_ex  out  1  EX receives a nop next edge
flush_id  out  1  squash the ID instruction
fwd_rs_sel  out  3  0 = regfile, k = result from scoreboard stage k
fwd_rt_sel  out  3  same encoding, for rt
halted  out  1  controller in HALTED state
stall_count  out  32  saturating count of RUN cycles with stall_if=1

Behaviour:
Reset and clocking:
- One clock; reset is synchronous and active-high.
- On rst all scoreboard entries are invalid, state=RUN, stall_count=0.
- With an empty scoreboard all outputs except stall_count are combinationally 0.

Scoreboard:
- Entry k (1..DEPTH) holds {valid, rd, wr, ld}.
- Every RUN edge: entry k <= entry k-1 for k>=2.
- Entry 1 <= the ID instruction if id_valid & !stall_if & !flush_id; otherwise a bubble (valid=0).
- Entries with rd=0 or wr=0 never match.

Forwarding (combinational from scoreboard + ID inputs), per operand X in {rs, rt}:
- If id_X_used=0, fwd_X_sel=0.
- Otherwise find the smallest k with valid & wr & rd==id_X & rd!=0.
- None found: sel=0.
- Match is a load with k<LOAD_LAT: load-use hazard, sel=0.
- Any other match: sel=k. The youngest match always wins over older matches.

Stall:
- stall_if = bubble_ex = (hazard on rs or rt) | (wb_exception==TRAP_STALL).
- Valid only when flush_id=0.

Branch:
- flush_id = ex_br_enable & !DELAY_SLOT.
- flush_id overrides stall: stall_if=0, ID instruction dropped, bubble enters EX.
- With DELAY_SLOT=1, branch has no effect on this block.

State machine:
- RUN -> HALTED when wb_exception!=0 and !=TRAP_STALL.
- HALTED on entry: scoreboard cleared (younger instructions killed).
- HALTED: halted=1, stall_if=1, bubble_ex=1, flush_id=0, fwd selects 0, stall_count frozen.
- HALTED is left only by rst. Reset mid-operation discards all state in one edge.

stall_count:
- Increments on each RUN edge with stall_if=1.
- Saturates at 32'hFFFFFFFF.

Test Plan:
- addu $3 then addu $5,$3,$4 on the next issue cycle -> fwd_rs_sel=1, fwd_rt_sel=0, stall_if=0.
- lw $4 then addu $6,$4,$4 (LOAD_LAT=2) -> one cycle stall_if=bubble_ex=1, then fwd_rs_sel=fwd_rt_sel=2; stall_count=1.
- addu $0,... followed by a reader of $0 -> both selects 0 and no stall; writes to $7 at stages 1 and 3 both match id_rs=$7 -> sel=1.
- Load-use hazard and ex_br_enable=1 on the same cycle (DELAY_SLOT=0) -> flush_id=1, stall_if=0, entry 1 bubble. Repeat with DELAY_SLOT=1 -> flush_id=0, stall_if=1.
- wb_exception=8'h01 -> halted=1 and stall_if=1 after the next edge, scoreboard empty, held 10 cycles. rst -> halted=0, stall_count=0. wb_exception=8'h80 -> one stall cycle only, no halt.
- DEPTH=4, LOAD_LAT=3: lw $9 then a reader of $9 -> two stall cycles, then fwd_rs_sel=3.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the ID-stage operand information, the branch/exception inputs and
// the hazard-control outputs exchanged between the decoder side and the
// hazard controller.
//
// Signals (direction seen from the hazard controller, i.e. modport slave):
//   in  id_valid      ID holds a real instruction
//   in  id_rs/id_rt   ID source register specifiers
//   in  id_rs_used    instruction reads rs
//   in  id_rt_used    instruction reads rt
//   in  id_rd         ID destination register
//   in  id_reg_write  instruction writes id_rd
//   in  id_mem2reg    instruction is a load
//   in  ex_br_enable  branch taken, resolved in EX this cycle
//   in  wb_exception  exception code at WB
//   out stall_if      hold PC and IR this cycle
//   out bubble_ex     EX receives a nop next edge
//   out flush_id      squash the ID instruction
//   out fwd_rs_sel    0 = regfile, k = result from scoreboard stage k
//   out fwd_rt_sel    same encoding, for rt
//   out halted        controller is halted
//   out stall_count   saturating count of RUN cycles with stall_if=1
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_BITS = 5,
    parameter int EXC_W    = 8
);
    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_rs_used;
    logic                id_rt_used;
    logic [REG_BITS-1:0] id_rd;
    logic                id_reg_write;
    logic                id_mem2reg;
    logic                ex_br_enable;
    logic [EXC_W-1:0]    wb_exception;
    logic                stall_if;
    logic                bubble_ex;
    logic                flush_id;
    logic [2:0]          fwd_rs_sel;
    logic [2:0]          fwd_rt_sel;
    logic                halted;
    logic [31:0]         stall_count;

    // Decoder / pipeline side
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_reg_write, id_mem2reg, ex_br_enable, wb_exception,
        input  stall_if, bubble_ex, flush_id, fwd_rs_sel, fwd_rt_sel,
               halted, stall_count
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_reg_write, id_mem2reg, ex_br_enable, wb_exception,
        output stall_if, bubble_ex, flush_id, fwd_rs_sel, fwd_rt_sel,
               halted, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the in-order MIPS core. A DEPTH-entry
// scoreboard shadows the instructions in EX..WB (entry 1 = EX). From it and
// the ID operand info the block derives per-operand forwarding selects,
// load-use stalls, branch squashes and a fatal-exception halt.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  hazard_ctrl_if.slave (ID operand info in, hazard controls out)
//
// Forwarding select encoding: 0 = register file, k = result of stage k.
// The select and stall outputs are combinational from the scoreboard and
// the ID inputs so the decoder can act on them in the same cycle.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int              REG_BITS   = 5,
    parameter int              DEPTH      = 3,
    parameter int              LOAD_LAT   = 2,
    parameter int              DELAY_SLOT = 0,
    parameter int              EXC_W      = 8,
    parameter logic [EXC_W-1:0] TRAP_STALL = EXC_W'(8'h80)
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // Forwarding lookup for one source operand. Returns {hazard, sel}.
    // Scans from the youngest stage (1) outward and stops at the first
    // match, so a younger writer always shadows an older one. A load that
    // has not yet reached LOAD_LAT cannot forward and raises the hazard.
    function automatic logic [3:0] fwd_lookup(
        input logic                            used,
        input logic [REG_BITS-1:0]             src,
        input logic [DEPTH:1]                  vld,
        input logic [DEPTH:1]                  wr,
        input logic [DEPTH:1]                  ld,
        input logic [DEPTH:1][REG_BITS-1:0]    rd
    );
        logic       hit;
        logic       haz;
        logic [2:0] sel;
        hit = 1'b0;
        haz = 1'b0;
        sel = 3'd0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!hit && used && vld[k] && wr[k] &&
                (rd[k] == src) && (rd[k] != {REG_BITS{1'b0}})) begin
                hit = 1'b1;
                if (ld[k] && (k < LOAD_LAT)) begin
                    haz = 1'b1;
                    sel = 3'd0;
                end else begin
                    haz = 1'b0;
                    sel = 3'(k);
                end
            end else begin
                hit = hit;
            end
        end
        return {haz, sel};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                         state_q, state_d;
    logic [DEPTH:1]                 sb_valid_q, sb_valid_d;
    logic [DEPTH:1]                 sb_wr_q, sb_wr_d;
    logic [DEPTH:1]                 sb_ld_q, sb_ld_d;
    logic [DEPTH:1][REG_BITS-1:0]   sb_rd_q, sb_rd_d;
    logic [31:0]                    stall_count_q, stall_count_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       trap_s;
    logic       fatal_s;
    logic       branch_s;
    logic [3:0] rs_look_s;
    logic [3:0] rt_look_s;
    logic       stall_if_s;
    logic       bubble_ex_s;
    logic       flush_id_s;
    logic [2:0] fwd_rs_sel_s;
    logic [2:0] fwd_rt_sel_s;
    logic       halted_s;

    // Exception decode and branch squash enable; with a delay slot the
    // branch never touches this block.
    always_comb begin
        trap_s   = (bus.wb_exception == TRAP_STALL);
        fatal_s  = (bus.wb_exception != {EXC_W{1'b0}}) && !trap_s;
        if (DELAY_SLOT == 0) begin
            branch_s = bus.ex_br_enable;
        end else begin
            branch_s = 1'b0;
        end
    end

    // Scoreboard lookups for both ID source operands.
    always_comb begin
        rs_look_s = fwd_lookup(bus.id_rs_used, bus.id_rs,
                               sb_valid_q, sb_wr_q, sb_ld_q, sb_rd_q);
        rt_look_s = fwd_lookup(bus.id_rt_used, bus.id_rt,
                               sb_valid_q, sb_wr_q, sb_ld_q, sb_rd_q);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // State register; HALTED is left only through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a non-trap exception at WB halts the controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (fatal_s) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM outputs. A branch squash wins over any stall: the ID instruction
    // is dropped, so holding it would be pointless, and EX gets a bubble.
    always_comb begin
        stall_if_s   = 1'b0;
        bubble_ex_s  = 1'b0;
        flush_id_s   = 1'b0;
        fwd_rs_sel_s = 3'd0;
        fwd_rt_sel_s = 3'd0;
        halted_s     = 1'b0;
        case (state_q)
            ST_RUN: begin
                fwd_rs_sel_s = rs_look_s[2:0];
                fwd_rt_sel_s = rt_look_s[2:0];
                if (branch_s) begin
                    flush_id_s  = 1'b1;
                    stall_if_s  = 1'b0;
                    bubble_ex_s = 1'b1;
                end else begin
                    flush_id_s  = 1'b0;
                    stall_if_s  = rs_look_s[3] | rt_look_s[3] | trap_s;
                    bubble_ex_s = rs_look_s[3] | rt_look_s[3] | trap_s;
                end
            end
            ST_HALTED: begin
                halted_s    = 1'b1;
                stall_if_s  = 1'b1;
                bubble_ex_s = 1'b1;
            end
            default: begin
                halted_s = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Scoreboard next value: shift one stage per RUN cycle and admit the ID
    // instruction only when it actually issues. Entering or sitting in
    // HALTED kills every tracked instruction.
    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_wr_d    = sb_wr_q;
        sb_ld_d    = sb_ld_q;
        sb_rd_d    = sb_rd_q;
        if ((state_q == ST_RUN) && !fatal_s) begin
            for (int k = DEPTH; k >= 2; k--) begin
                sb_valid_d[k] = sb_valid_q[k-1];
                sb_wr_d[k]    = sb_wr_q[k-1];
                sb_ld_d[k]    = sb_ld_q[k-1];
                sb_rd_d[k]    = sb_rd_q[k-1];
            end
            sb_valid_d[1] = bus.id_valid & !stall_if_s & !flush_id_s;
            sb_wr_d[1]    = bus.id_reg_write;
            sb_ld_d[1]    = bus.id_mem2reg;
            sb_rd_d[1]    = bus.id_rd;
        end else begin
            sb_valid_d = {DEPTH{1'b0}};
            sb_wr_d    = {DEPTH{1'b0}};
            sb_ld_d    = {DEPTH{1'b0}};
            sb_rd_d    = {(DEPTH*REG_BITS){1'b0}};
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q <= {DEPTH{1'b0}};
            sb_wr_q    <= {DEPTH{1'b0}};
            sb_ld_q    <= {DEPTH{1'b0}};
            sb_rd_q    <= {(DEPTH*REG_BITS){1'b0}};
        end else begin
            sb_valid_q <= sb_valid_d;
            sb_wr_q    <= sb_wr_d;
            sb_ld_q    <= sb_ld_d;
            sb_rd_q    <= sb_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------
    // Counts RUN cycles spent stalled; sticks at all-ones and freezes while
    // halted (halt stalls are not pipeline hazards).
    always_comb begin
        if ((state_q == ST_RUN) && stall_if_s &&
            (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall_if    = stall_if_s;
    assign bus.bubble_ex   = bubble_ex_s;
    assign bus.flush_id    = flush_id_s;
    assign bus.fwd_rs_sel  = fwd_rs_sel_s;
    assign bus.fwd_rt_sel  = fwd_rt_sel_s;
    assign bus.halted      = halted_s;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Three instances share one stimulus:
//   dut_a: DEPTH=3, LOAD_LAT=2, DELAY_SLOT=0
//   dut_b: DEPTH=3, LOAD_LAT=2, DELAY_SLOT=1
//   dut_c: DEPTH=4, LOAD_LAT=3, DELAY_SLOT=0
// Inputs change 1 time unit after a rising edge; outputs are compared on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsu;
        logic       rtu;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic [7:0] exc;
    } in_t;

    typedef struct {
        in_t        i;
        logic [9:0] e;   // {stall, bubble, flush, rs_sel, rt_sel, halted}
    } vec_t;

    localparam int NV = 19;

    logic clk;
    logic rst;
    in_t  cur;
    int   total;
    int   bad;
    vec_t tbl [NV];

    hazard_ctrl_if #(.REG_BITS(5), .EXC_W(8)) ifs [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_drv
        assign ifs[g].id_valid     = cur.valid;
        assign ifs[g].id_rs        = cur.rs;
        assign ifs[g].id_rt        = cur.rt;
        assign ifs[g].id_rs_used   = cur.rsu;
        assign ifs[g].id_rt_used   = cur.rtu;
        assign ifs[g].id_rd        = cur.rd;
        assign ifs[g].id_reg_write = cur.wr;
        assign ifs[g].id_mem2reg   = cur.ld;
        assign ifs[g].ex_br_enable = cur.br;
        assign ifs[g].wb_exception = cur.exc;
    end

    hazard_ctrl #(.REG_BITS(5), .DEPTH(3), .LOAD_LAT(2), .DELAY_SLOT(0),
                  .EXC_W(8), .TRAP_STALL(8'h80))
        dut_a (.clk(clk), .rst(rst), .bus(ifs[0]));
    hazard_ctrl #(.REG_BITS(5), .DEPTH(3), .LOAD_LAT(2), .DELAY_SLOT(1),
                  .EXC_W(8), .TRAP_STALL(8'h80))
        dut_b (.clk(clk), .rst(rst), .bus(ifs[1]));
    hazard_ctrl #(.REG_BITS(5), .DEPTH(4), .LOAD_LAT(3), .DELAY_SLOT(0),
                  .EXC_W(8), .TRAP_STALL(8'h80))
        dut_c (.clk(clk), .rst(rst), .bus(ifs[2]));

    logic [9:0] outs_a, outs_b, outs_c;
    assign outs_a = {ifs[0].stall_if, ifs[0].bubble_ex, ifs[0].flush_id,
                     ifs[0].fwd_rs_sel, ifs[0].fwd_rt_sel, ifs[0].halted};
    assign outs_b = {ifs[1].stall_if, ifs[1].bubble_ex, ifs[1].flush_id,
                     ifs[1].fwd_rs_sel, ifs[1].fwd_rt_sel, ifs[1].halted};
    assign outs_c = {ifs[2].stall_if, ifs[2].bubble_ex, ifs[2].flush_id,
                     ifs[2].fwd_rs_sel, ifs[2].fwd_rt_sel, ifs[2].halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic rsu,
                               input logic rtu, input logic [4:0] rd,
                               input logic wr, input logic ld,
                               input logic br, input logic [7:0] exc);
        in_t r;
        r.valid = v;  r.rs = rs;  r.rt = rt;  r.rsu = rsu;  r.rtu = rtu;
        r.rd = rd;    r.wr = wr;  r.ld = ld;  r.br = br;    r.exc = exc;
        return r;
    endfunction

    function automatic logic [9:0] pk(input logic s, input logic b,
                                      input logic f, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic h);
        return {s, b, f, rs, rt, h};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cur = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        in_t idle;
        in_t rdr;
        total = 0;
        bad   = 0;
        idle  = '0;
        cur   = '0;
        rst   = 1'b1;

        //                 v   rs  rt  rsu rtu rd  wr  ld  br  exc          s b f rs rt h
        tbl[0]  = '{idle,                                              pk(0,0,0,0,0,0)};
        tbl[1]  = '{mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 8'h00),              pk(0,0,0,0,0,0)};
        tbl[2]  = '{mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 8'h00),              pk(0,0,0,1,0,0)};
        tbl[3]  = '{mk(1, 3, 5, 1, 1, 6, 1, 0, 0, 8'h00),              pk(0,0,0,2,1,0)};
        tbl[4]  = '{mk(1, 3, 6, 0, 1, 7, 1, 0, 0, 8'h00),              pk(0,0,0,0,1,0)};
        tbl[5]  = '{mk(1, 5, 4, 1, 0, 4, 1, 1, 0, 8'h00),              pk(0,0,0,3,0,0)};
        tbl[6]  = '{mk(1, 4, 4, 1, 1, 8, 1, 0, 0, 8'h00),              pk(1,1,0,0,0,0)};
        tbl[7]  = '{mk(1, 4, 4, 1, 1, 8, 1, 0, 0, 8'h00),              pk(0,0,0,2,2,0)};
        tbl[8]  = '{mk(1, 7, 8, 1, 1, 0, 1, 0, 0, 8'h00),              pk(0,0,0,0,1,0)};
        tbl[9]  = '{mk(1, 0, 0, 1, 1, 7, 1, 0, 0, 8'h00),              pk(0,0,0,0,0,0)};
        tbl[10] = '{idle,                                              pk(0,0,0,0,0,0)};
        tbl[11] = '{mk(1, 1, 2, 1, 1, 7, 1, 0, 0, 8'h00),              pk(0,0,0,0,0,0)};
        tbl[12] = '{mk(1, 7, 7, 1, 1, 9, 0, 0, 0, 8'h00),              pk(0,0,0,1,1,0)};
        tbl[13] = '{mk(1, 9, 7, 1, 1, 0, 0, 0, 0, 8'h00),              pk(0,0,0,0,2,0)};
        tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80),              pk(1,1,0,0,0,0)};
        tbl[15] = '{idle,                                              pk(0,0,0,0,0,0)};
        tbl[16] = '{mk(1, 1, 2, 1, 1,10, 1, 1, 0, 8'h00),              pk(0,0,0,0,0,0)};
        tbl[17] = '{mk(1,10, 2, 1, 1,11, 1, 0, 1, 8'h00),              pk(0,1,1,0,0,0)};
        tbl[18] = '{mk(1,10, 2, 1, 1,11, 1, 0, 0, 8'h00),              pk(0,0,0,2,0,0)};

        do_reset();
        @(negedge clk);
        chk("reset stall_count", ifs[0].stall_count, 32'd0);
        next_cycle();

        // Table run on dut_a: forwarding, load-use, $0, double match, trap, branch.
        for (int n = 0; n < NV; n++) begin
            cur = tbl[n].i;
            @(negedge clk);
            chk($sformatf("vec%0d s/b/f/rs/rt/h", n), {22'd0, outs_a},
                {22'd0, tbl[n].e});
            next_cycle();
        end
        chk("table stall_count", ifs[0].stall_count, 32'd2);

        // Fatal exception: outputs normal this cycle, halted from next edge.
        cur = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 8'h01);
        @(negedge clk);
        chk("pre-halt outs", {22'd0, outs_a}, {22'd0, pk(0,0,0,0,0,0)});
        next_cycle();
        rdr = mk(1, 11, 3, 1, 1, 4, 1, 0, 1, 8'h00);
        cur = rdr;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("halt%0d outs", c), {22'd0, outs_a},
                {22'd0, pk(1,1,0,0,0,1)});
            chk($sformatf("halt%0d stall_count", c), ifs[0].stall_count, 32'd2);
            next_cycle();
        end

        // Reset from HALTED clears everything in one edge.
        rst = 1'b1;
        cur = idle;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst halted", {31'd0, ifs[0].halted}, 32'd0);
        chk("post-rst stall_count", ifs[0].stall_count, 32'd0);
        next_cycle();

        // Trap code: exactly one stall cycle, no halt.
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80);
        @(negedge clk);
        chk("trap outs", {22'd0, outs_a}, {22'd0, pk(1,1,0,0,0,0)});
        next_cycle();
        cur = idle;
        @(negedge clk);
        chk("after-trap outs", {22'd0, outs_a}, {22'd0, pk(0,0,0,0,0,0)});
        chk("after-trap stall_count", ifs[0].stall_count, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("after-trap halted", {31'd0, ifs[0].halted}, 32'd0);
        next_cycle();

        // Load-use and taken branch together: squash (a) vs delay slot (b).
        do_reset();
        cur = mk(1, 1, 2, 1, 1, 4, 1, 1, 0, 8'h00);
        next_cycle();
        cur = mk(1, 4, 5, 1, 1, 6, 1, 0, 1, 8'h00);
        @(negedge clk);
        chk("br+lu squash a", {22'd0, outs_a}, {22'd0, pk(0,1,1,0,0,0)});
        chk("br+lu dslot b", {22'd0, outs_b}, {22'd0, pk(1,1,0,0,0,0)});
        next_cycle();

        // DEPTH=4, LOAD_LAT=3: two stall cycles then forward from stage 3.
        do_reset();
        cur = mk(1, 1, 2, 1, 1, 9, 1, 1, 0, 8'h00);
        next_cycle();
        cur = mk(1, 9, 2, 1, 0, 3, 1, 0, 0, 8'h00);
        @(negedge clk);
        chk("d4 stall1", {22'd0, outs_c}, {22'd0, pk(1,1,0,0,0,0)});
        next_cycle();
        @(negedge clk);
        chk("d4 stall2", {22'd0, outs_c}, {22'd0, pk(1,1,0,0,0,0)});
        next_cycle();
        @(negedge clk);
        chk("d4 fwd3", {22'd0, outs_c}, {22'd0, pk(0,0,0,3,0,0)});
        chk("d4 stall_count", ifs[2].stall_count, 32'd2);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
